// File: rtl/seg7_display_driver.sv
// seg7_display_driver: double-buffered six-digit 7-segment driver with blink and PWM dimming.
// Latency: load -> shadow at the same edge, shadow -> HEX one edge later (2 edges total).
// Backpressure: none; load is level-sampled every cycle and always accepted.
//
// Ports:
//   clk, reset_n          : system clock, asynchronous active-low reset
//   load                  : capture num0..num5 into the shadow registers
//   num0..num5  [31:0]    : digit codes (0-9 digit, 11 dash, anything else blank); num0 is rightmost
//   blink_mask  [5:0]     : bit i makes digit i blink
//   brightness  [3:0]     : PWM duty (brightness+1)/16
//   HEX0..HEX5  [6:0]     : registered active-low segments {g,f,e,d,c,b,a}
module seg7_display_driver #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] num0,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic [31:0] num3,
  input  logic [31:0] num4,
  input  logic [31:0] num5,
  input  logic [5:0]  blink_mask,
  input  logic [3:0]  brightness,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  logic [31:0]   num_in   [6];
  logic [3:0]    code_q   [6];
  logic [6:0]    hex_d    [6];
  logic [6:0]    hex_q    [6];
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    pwm_cnt;
  logic          pwm_on;

  assign num_in[0] = num0;
  assign num_in[1] = num1;
  assign num_in[2] = num2;
  assign num_in[3] = num3;
  assign num_in[4] = num4;
  assign num_in[5] = num5;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      4'd11:   seg = 7'h3F;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // Shadow registers: the full 32-bit code is range-checked so that large
  // values never alias onto a valid digit through truncation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) code_q[i] <= CODE_BLANK;
    end else if (load) begin
      for (int i = 0; i < 6; i++)
        code_q[i] <= (num_in[i] <= 32'd11) ? num_in[i][3:0] : CODE_BLANK;
    end
  end

  // Blink timer; a load restarts it in the visible phase so an edited value
  // shows at once, even if the counter was about to wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (load) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Free-running PWM counter, independent of load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign pwm_on = (pwm_cnt <= brightness);

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hex_d[i] = decode(code_q[i]);
      if (!pwm_on)                           hex_d[i] = SEG_OFF;
      else if (blink_mask[i] && !blink_phase) hex_d[i] = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_OFF;
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_seg7_display_driver.sv
// Testbench for seg7_display_driver with BLINK_DIV = 4.
// Reference model: shadow codes, edges since last load/reset, and edges since reset.
// Visibility and PWM are derived arithmetically from those counts.
module tb_seg7_display_driver;

  localparam int DIV = 4;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [31:0] num [6];
  logic [5:0]  blink_mask;
  logic [3:0]  brightness;
  wire  [6:0]  hex [6];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int         m_code [6];
  int         m_since_load;
  int         m_since_reset;
  logic [6:0] m_hex [6];

  logic [6:0] seg_tab [16];

  seg7_display_driver #(.BLINK_DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .num0       (num[0]),
    .num1       (num[1]),
    .num2       (num[2]),
    .num3       (num[3]),
    .num4       (num[4]),
    .num5       (num[5]),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .HEX0       (hex[0]),
    .HEX1       (hex[1]),
    .HEX2       (hex[2]),
    .HEX3       (hex[3]),
    .HEX4       (hex[4]),
    .HEX5       (hex[5])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_code[i] = 10;
      m_hex[i]  = 7'h7F;
    end
    m_since_load  = 0;
    m_since_reset = 0;
  endtask

  function automatic int sanitize(input logic [31:0] v);
    return (v <= 32'd11) ? int'(v) : 10;
  endfunction

  // One clock edge: predict what HEX registers from the pre-edge state,
  // advance the model, then compare after the edge.
  task automatic tick();
    logic [6:0] e [6];
    bit lit, visible;
    lit     = ((m_since_reset % 16) <= int'(brightness));
    visible = (((m_since_load / DIV) % 2) == 0);
    for (int i = 0; i < 6; i++) begin
      if (!lit)                             e[i] = 7'h7F;
      else if (blink_mask[i] && !visible)   e[i] = 7'h7F;
      else                                  e[i] = seg_tab[m_code[i]];
    end
    @(posedge clk);
    if (load) begin
      for (int i = 0; i < 6; i++) m_code[i] = sanitize(num[i]);
      m_since_load = 0;
    end else begin
      m_since_load++;
    end
    m_since_reset++;
    for (int i = 0; i < 6; i++) m_hex[i] = e[i];
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("model_hex%0d", i), hex[i], m_hex[i]);
  endtask

  initial begin
    int lit_cnt [6];
    logic [31:0] first_set [6];
    logic [6:0]  first_exp [6];

    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h7F; seg_tab[11] = 7'h3F;
    seg_tab[12] = 7'h7F; seg_tab[13] = 7'h7F; seg_tab[14] = 7'h7F; seg_tab[15] = 7'h7F;

    reset_n    = 1'b0;
    load       = 1'b0;
    blink_mask = 6'b0;
    brightness = 4'd15;
    for (int i = 0; i < 6; i++) num[i] = 32'd0;
    model_reset();

    // Reset state, checked while reset is still held.
    #12;
    for (int i = 0; i < 6; i++) check($sformatf("reset_hex%0d", i), hex[i], 7'h7F);
    #1 reset_n = 1'b1;

    // First load: num5..num0 = {0, 11, 10, 10, 4, 2}.
    first_set[0] = 32'd2;  first_set[1] = 32'd4;  first_set[2] = 32'd10;
    first_set[3] = 32'd10; first_set[4] = 32'd11; first_set[5] = 32'd0;
    first_exp[0] = 7'h24;  first_exp[1] = 7'h19;  first_exp[2] = 7'h7F;
    first_exp[3] = 7'h7F;  first_exp[4] = 7'h3F;  first_exp[5] = 7'h40;
    tick();
    for (int i = 0; i < 6; i++) num[i] = first_set[i];
    load = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) check($sformatf("preload_hex%0d", i), hex[i], 7'h7F);
    load = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) check($sformatf("first_hex%0d", i), hex[i], first_exp[i]);

    // Invalid codes.
    num[0] = 32'd12; num[1] = 32'h0000_0010; num[2] = 32'hFFFF_FFFF;
    num[3] = 32'd3;  num[4] = 32'd5;         num[5] = 32'd9;
    load = 1'b1; tick(); load = 1'b0; tick();
    for (int i = 0; i < 3; i++) check($sformatf("invalid_hex%0d", i), hex[i], 7'h7F);
    check("valid_hex3", hex[3], 7'h30);

    // Hold without load for 100 cycles, then load all 8s.
    for (int i = 0; i < 6; i++) num[i] = 32'd8;
    for (int c = 0; c < 100; c++) tick();
    check("hold_hex5", hex[5], 7'h10);
    load = 1'b1; tick(); load = 1'b0; tick();
    for (int i = 0; i < 6; i++) check($sformatf("all8_hex%0d", i), hex[i], 7'h00);

    // Blink on digit 0 with num0 = 7.
    num[0] = 32'd7;
    blink_mask = 6'b000001;
    load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("blink_on_hex0", hex[0], 7'h78);
      check("noblink_hex1", hex[1], 7'h00);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      check("blink_off_hex0", hex[0], 7'h7F);
      check("noblink_hex5", hex[5], 7'h00);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      check("blink_on2_hex0", hex[0], 7'h78);
    end
    tick(); tick();
    check("blank_before_reload", hex[0], 7'h7F);
    load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("reload_visible_hex0", hex[0], 7'h78);
    end
    tick();
    check("reload_then_blank_hex0", hex[0], 7'h7F);
    blink_mask = 6'b0;

    // Brightness 3 then 0: count lit cycles over a 16-cycle window.
    for (int i = 0; i < 6; i++) num[i] = 32'd8;
    load = 1'b1; tick(); load = 1'b0;
    brightness = 4'd3;
    tick();
    for (int i = 0; i < 6; i++) lit_cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < 6; i++) if (hex[i] == 7'h00) lit_cnt[i]++;
    end
    for (int i = 0; i < 6; i++) check($sformatf("bright3_lit%0d", i), lit_cnt[i], 4);
    brightness = 4'd0;
    tick();
    for (int i = 0; i < 6; i++) lit_cnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < 6; i++) if (hex[i] == 7'h00) lit_cnt[i]++;
    end
    for (int i = 0; i < 6; i++) check($sformatf("bright0_lit%0d", i), lit_cnt[i], 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      load = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 6; i++)
        num[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blink_mask = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) brightness = 4'($urandom_range(0, 15));
      tick();
    end

    // Asynchronous reset while lit and blinking.
    brightness = 4'd15;
    blink_mask = 6'b111111;
    for (int i = 0; i < 6; i++) num[i] = 32'(i + 1);
    load = 1'b1; tick(); load = 1'b0; tick();
    check("prereset_hex0", hex[0], 7'h79);
    check("prereset_hex5", hex[5], 7'h02);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) check($sformatf("async_reset_hex%0d", i), hex[i], 7'h7F);
    model_reset();
    #2 reset_n = 1'b1;
    blink_mask = 6'b0;
    for (int c = 0; c < 10; c++) tick();
    for (int i = 0; i < 6; i++) check($sformatf("post_reset_blank_hex%0d", i), hex[i], 7'h7F);
    load = 1'b1; tick(); load = 1'b0; tick();
    check("post_reset_load_hex2", hex[2], 7'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
